hex_word_tx: RTL

- Transmit-side companion to the UART terminal path.
- Takes the processor's 16-bit result word and converts it to printable ASCII hex, most-significant nibble first, with an optional CR/LF terminator.
- Pushes the characters one at a time into the UART driver's transmit FIFO, using that FIFO's write-data / write-strobe / full handshake.
- A host terminal therefore sees every result the processor produces, mirroring the receive path that feeds instruction bytes in.

---
 rtl/hex_tx_pkg.sv | 10 +
 rtl/hex_word_tx_if.sv | 13 +
 rtl/nibble_to_ascii.sv | 14 +
 rtl/hex_word_tx.sv | 88 ++++++++
 4 files changed

// File: rtl/hex_tx_pkg.sv
// Shared types and ASCII constants for the hex word transmitter.
package hex_tx_pkg;
    typedef enum logic [1:0] {IDLE, EMIT, FINISH} state_t;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_A_UP = 8'h41;
    localparam logic [7:0] ASCII_A_LO = 8'h61;
endpackage

// File: rtl/hex_word_tx_if.sv
// Word-in / UART-FIFO-out bundle for hex_word_tx.
interface hex_word_tx_if #(parameter int DATA_W = 16);
    logic [DATA_W-1:0] data_in;
    logic              send;
    logic              tx_full;
    logic [7:0]        w_data;
    logic              wr_uart;
    logic              busy;
    logic              done;

    modport master (output data_in, send, tx_full, input w_data, wr_uart, busy, done);
    modport slave  (input data_in, send, tx_full, output w_data, wr_uart, busy, done);
endinterface

// File: rtl/nibble_to_ascii.sv
// Maps one hex nibble to its printable ASCII character.
module nibble_to_ascii
    import hex_tx_pkg::*;
#(
    parameter bit UPPERCASE = 1'b1
) (
    input  logic [3:0] nib,
    output logic [7:0] ch
);
    always_comb begin
        if (nib < 4'd10) ch = ASCII_0 + {4'b0, nib};
        else             ch = (UPPERCASE ? ASCII_A_UP : ASCII_A_LO) + {4'b0, nib} - 8'd10;
    end
endmodule

// File: rtl/hex_word_tx.sv
// Prints a latched data word as ASCII hex (MSB first, optional CR/LF) into a UART TX FIFO.
module hex_word_tx
    import hex_tx_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter bit APPEND_CRLF    = 1'b1,
    parameter bit UPPERCASE      = 1'b1,
    parameter bit AUTO_ON_CHANGE = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    hex_word_tx_if.slave  bus
);
    localparam int N     = DATA_W / 4;
    localparam int NCHAR = N + (APPEND_CRLF ? 2 : 0);
    localparam int IDX_W = $clog2(NCHAR + 1);

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shadow, last_seen;
    logic [3:0]        nib;
    logic [7:0]        hex_ch, ch;
    logic              load, wr;

    // Constant-indexed mux keeps the nibble select free of variable part-selects.
    always_comb begin
        nib = 4'h0;
        for (int i = 0; i < N; i++)
            if (idx == IDX_W'(i)) nib = shadow[4*(N-1-i) +: 4];
    end

    nibble_to_ascii #(.UPPERCASE(UPPERCASE)) u_n2a (.nib(nib), .ch(hex_ch));

    always_comb begin
        if (idx < IDX_W'(N))       ch = hex_ch;
        else if (idx == IDX_W'(N)) ch = ASCII_CR;
        else                       ch = ASCII_LF;
    end

    always_comb begin
        state_n     = state;
        load        = 1'b0;
        wr          = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.w_data  = 8'h00;
        case (state)
            IDLE: begin
                if (bus.send || (AUTO_ON_CHANGE && (bus.data_in != last_seen))) begin
                    load    = 1'b1;
                    state_n = EMIT;
                end
            end
            EMIT: begin
                bus.busy   = 1'b1;
                bus.w_data = ch;
                wr         = ~bus.tx_full;
                if (wr && (idx == IDX_W'(NCHAR - 1))) state_n = FINISH;
            end
            FINISH: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.wr_uart = wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            shadow    <= '0;
            last_seen <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                shadow    <= bus.data_in;
                last_seen <= bus.data_in;
                idx       <= '0;
            end else if (wr) begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule
